// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32IM control FSM: fetch/decode/execute/memory/writeback with
// an instruction register, mem and mul/div handshakes, and a retire counter.
module rv_multicycle_ctrl #(
    parameter int MULDIV_EN  = 1,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic             muldiv_start,
    input  logic             muldiv_done,
    output logic             ir_we,
    output logic             pc_we,
    output logic [5:0]       ALUSel,
    output logic             ALUSrc,
    output logic             RegWEn,
    output logic             MemRW,
    output logic [3:0]       MemtoReg,
    output logic [2:0]       selStore,
    output logic             illegal,
    output logic             md_timeout,
    output logic [CNT_W-1:0] retired
);
    localparam int TW = $clog2(MD_TIMEOUT + 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MD_WAIT, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_ALU, C_MD, C_LD, C_ST, C_JALR} cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [5:0] alusel;
        logic       alusrc;
        logic       memrw;
        logic [3:0] m2r;
        logic [2:0] sels;
    } ctrl_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctrl_t            ctrl_q, ctrl_d, dec;
    logic             dec_ill;

    logic [2:0] f3;
    logic [6:0] f7;
    assign f3 = ir_q[14:12];
    assign f7 = ir_q[31:25];

    wire unused_ir = ^{ir_q[24:15], ir_q[11:7]};

    always_comb begin
        dec     = '0;
        dec_ill = 1'b0;
        unique case (ir_q[6:0])
            OP_R: begin
                dec.cls    = C_ALU;
                dec.alusel = {f3, f7[5], 2'b00};
                if (f7 == 7'b0000001) begin
                    dec.cls    = C_MD;
                    dec.alusel = {f3, 3'b001};
                    dec_ill    = (MULDIV_EN == 0);
                end else if (f7 == 7'b0100000) begin
                    dec_ill = !(f3 == 3'b000 || f3 == 3'b101);
                end else if (f7 != 7'b0000000) begin
                    dec_ill = 1'b1;
                end
            end
            OP_I: begin
                dec.cls    = C_ALU;
                dec.alusrc = 1'b1;
                // shift-right immediates carry the arithmetic flag in imm[10]
                dec.alusel = (f3 == 3'b101) ? {3'b101, ir_q[30], 2'b00} : {f3, 3'b000};
            end
            OP_LD: begin
                dec.cls    = C_LD;
                dec.alusrc = 1'b1;
                dec.m2r    = {f3, 1'b1};
                dec_ill    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_ST: begin
                dec.cls    = C_ST;
                dec.alusrc = 1'b1;
                dec.memrw  = 1'b1;
                dec.sels   = f3;
                dec_ill    = (f3 > 3'b010);
            end
            OP_JALR: begin
                dec.cls    = C_JALR;
                dec.alusrc = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_q;
        retired_d    = retired_q;
        instr_ready  = 1'b0;
        ir_we        = 1'b0;
        mem_req      = 1'b0;
        muldiv_start = 1'b0;
        pc_we        = 1'b0;
        RegWEn       = 1'b0;
        illegal      = 1'b0;
        md_timeout   = 1'b0;
        ALUSel       = '0;
        ALUSrc       = 1'b0;
        MemRW        = 1'b0;
        MemtoReg     = '0;
        selStore     = '0;

        if (state_q != S_FETCH && state_q != S_DECODE) begin
            ALUSel   = ctrl_q.alusel;
            ALUSrc   = ctrl_q.alusrc;
            MemRW    = ctrl_q.memrw;
            MemtoReg = ctrl_q.m2r;
            selStore = ctrl_q.sels;
        end

        unique case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_ill) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    ctrl_d  = dec;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (ctrl_q.cls)
                    C_MD: begin
                        muldiv_start = 1'b1;
                        cnt_d        = '0;
                        state_d      = S_MD_WAIT;
                    end
                    C_LD, C_ST: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MD_WAIT: begin
                // done takes priority over a timeout landing in the same cycle
                if (muldiv_done) begin
                    state_d = S_WB;
                end else if (cnt_q == TW'(MD_TIMEOUT - 1)) begin
                    md_timeout = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = S_WB;
            end
            S_WB: begin
                pc_we     = 1'b1;
                RegWEn    = (ctrl_q.cls != C_ST);
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: directed and random instructions checked cycle
// by cycle against an instruction-level model of the controller.
module tb_rv_multicycle_ctrl;
    localparam int MD_T = 8;
    localparam int K_ALU = 0, K_MD = 1, K_LD = 2, K_ST = 3, K_J = 4;

    typedef struct {
        bit legal;
        int cls;
        int alusel;
        bit alusrc;
        bit memrw;
        int m2r;
        int sels;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid, mem_ack, muldiv_done;
    logic        instr_ready, mem_req, muldiv_start, ir_we, pc_we;
    logic [5:0]  ALUSel;
    logic        ALUSrc, RegWEn, MemRW;
    logic [3:0]  MemtoReg;
    logic [2:0]  selStore;
    logic        illegal, md_timeout;
    logic [31:0] retired;

    logic [31:0] b_instr;
    logic        b_valid, b_ready, b_mem_req, b_mds, b_irwe, b_pcwe;
    logic [5:0]  b_alusel;
    logic        b_alusrc, b_rwe, b_memrw, b_ill, b_mto;
    logic [3:0]  b_m2r;
    logic [2:0]  b_sels;
    logic [31:0] b_retired;

    int tests = 0;
    int fails = 0;
    int exp_ret = 0;
    int m2r_tab [8] = '{1, 3, 5, 0, 9, 11, 0, 0};

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.MULDIV_EN(1), .MD_TIMEOUT(MD_T), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_req(mem_req), .mem_ack(mem_ack),
        .muldiv_start(muldiv_start), .muldiv_done(muldiv_done), .ir_we(ir_we),
        .pc_we(pc_we), .ALUSel(ALUSel), .ALUSrc(ALUSrc), .RegWEn(RegWEn),
        .MemRW(MemRW), .MemtoReg(MemtoReg), .selStore(selStore),
        .illegal(illegal), .md_timeout(md_timeout), .retired(retired)
    );

    rv_multicycle_ctrl #(.MULDIV_EN(0), .MD_TIMEOUT(4), .CNT_W(32)) dut_nomd (
        .clk(clk), .rst(rst), .instr(b_instr), .instr_valid(b_valid),
        .instr_ready(b_ready), .mem_req(b_mem_req), .mem_ack(1'b0),
        .muldiv_start(b_mds), .muldiv_done(1'b0), .ir_we(b_irwe),
        .pc_we(b_pcwe), .ALUSel(b_alusel), .ALUSrc(b_alusrc), .RegWEn(b_rwe),
        .MemRW(b_memrw), .MemtoReg(b_m2r), .selStore(b_sels),
        .illegal(b_ill), .md_timeout(b_mto), .retired(b_retired)
    );

    function automatic exp_t model(input logic [31:0] w, input bit md_en);
        exp_t e;
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        e = '{default: 0};
        e.legal = 1;
        case (w[6:0])
            7'h33: begin
                if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) begin
                    e.cls = K_ALU; e.alusel = f3 * 8 + (f7 == 32 ? 4 : 0);
                end else if (f7 == 1 && md_en) begin
                    e.cls = K_MD; e.alusel = f3 * 8 + 1;
                end else e.legal = 0;
            end
            7'h13: begin e.cls = K_ALU; e.alusrc = 1; e.alusel = f3 * 8 + ((f3 == 5 && w[30]) ? 4 : 0); end
            7'h03: begin e.cls = K_LD; e.alusrc = 1; e.m2r = m2r_tab[f3]; e.legal = (m2r_tab[f3] > 0); end
            7'h23: begin e.cls = K_ST; e.alusrc = 1; e.memrw = 1; e.sels = f3; e.legal = (f3 <= 2); end
            7'h67: begin e.cls = K_J; e.alusrc = 1; end
            default: e.legal = 0;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string ph, input bit rdy, input bit irwe, input bit mreq,
                           input bit mds, input bit pcwe, input bit rwe, input bit ill,
                           input bit mto, input bit ctl, input exp_t e);
        chk({ph, ".instr_ready"}, 32'(instr_ready), 32'(rdy));
        chk({ph, ".ir_we"}, 32'(ir_we), 32'(irwe));
        chk({ph, ".mem_req"}, 32'(mem_req), 32'(mreq));
        chk({ph, ".muldiv_start"}, 32'(muldiv_start), 32'(mds));
        chk({ph, ".pc_we"}, 32'(pc_we), 32'(pcwe));
        chk({ph, ".RegWEn"}, 32'(RegWEn), 32'(rwe));
        chk({ph, ".illegal"}, 32'(illegal), 32'(ill));
        chk({ph, ".md_timeout"}, 32'(md_timeout), 32'(mto));
        chk({ph, ".ALUSel"}, 32'(ALUSel), ctl ? 32'(e.alusel) : 32'd0);
        chk({ph, ".ALUSrc"}, 32'(ALUSrc), ctl ? 32'(e.alusrc) : 32'd0);
        chk({ph, ".MemRW"}, 32'(MemRW), ctl ? 32'(e.memrw) : 32'd0);
        chk({ph, ".MemtoReg"}, 32'(MemtoReg), ctl ? 32'(e.m2r) : 32'd0);
        chk({ph, ".selStore"}, 32'(selStore), ctl ? 32'(e.sels) : 32'd0);
        chk({ph, ".retired"}, retired, 32'(exp_ret));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // dly: MEM ack arrives on wait cycle dly (0-based); mul/div done on MD_WAIT
    // cycle dly (1-based), with dly > MD_T meaning it never comes in time.
    task automatic run_instr(input logic [31:0] w, input int dly);
        exp_t e = model(w, 1'b1);
        exp_t z = '{default: 0};
        int   nw;
        bit   to;
        instr = w; instr_valid = 1'b1;
        mem_ack = 1'($urandom_range(0, 1)); muldiv_done = 1'($urandom_range(0, 1));
        @(negedge clk); chk_all("fetch", 1, 1, 0, 0, 0, 0, 0, 0, 0, z); tick();
        instr_valid = 1'b0; instr = $urandom;
        @(negedge clk); chk_all("decode", 0, 0, 0, 0, 0, 0, !e.legal, 0, 0, z); tick();
        if (!e.legal) return;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk); chk_all("exec", 0, 0, 0, e.cls == K_MD, 0, 0, 0, 0, 1, e); tick();
        if (e.cls == K_LD || e.cls == K_ST) begin
            for (int k = 0; k <= dly; k++) begin
                mem_ack = (k == dly); muldiv_done = 1'($urandom_range(0, 1));
                @(negedge clk); chk_all("mem", 0, 0, 1, 0, 0, 0, 0, 0, 1, e); tick();
            end
        end else if (e.cls == K_MD) begin
            to = (dly > MD_T);
            nw = to ? MD_T : dly;
            for (int k = 1; k <= nw; k++) begin
                muldiv_done = (k == dly); mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk); chk_all("mdwait", 0, 0, 0, 0, 0, 0, 0, to && k == nw, 1, e); tick();
            end
            muldiv_done = 1'b0;
            if (to) return;
        end
        mem_ack = 1'($urandom_range(0, 1)); muldiv_done = 1'($urandom_range(0, 1));
        @(negedge clk); chk_all("wb", 0, 0, 0, 0, 1, e.cls != K_ST, 0, 0, 1, e); tick();
        exp_ret++;
    endtask

    logic [6:0] ops  [5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67};
    logic [6:0] f7s  [3] = '{7'h00, 7'h20, 7'h01};

    initial begin
        exp_t z = '{default: 0};
        logic [31:0] w;
        rst = 1'b1; instr = '0; instr_valid = 1'b0; mem_ack = 1'b0; muldiv_done = 1'b0;
        b_instr = '0; b_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk); chk_all("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, z); tick();

        run_instr(32'h002081B3, 0);   // add
        run_instr(32'h402081B3, 0);   // sub
        run_instr(32'h4030D293, 0);   // srai
        run_instr(32'h0080A283, 3);   // lw, ack after 3 wait cycles
        run_instr(32'h0050A223, 0);   // sw
        run_instr(32'h022081B3, 5);   // mul, done on 5th wait cycle
        run_instr(32'h022081B3, MD_T);      // done coincides with timeout: done wins
        run_instr(32'h022081B3, MD_T + 5);  // never done: timeout
        run_instr(32'hFFFFFFFF, 0);
        run_instr(32'h000080E7, 0);   // jalr

        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            if ($urandom_range(0, 5) != 0) w[6:0] = ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 2)];
            run_instr(w, $urandom_range(1, MD_T + 2));
            for (int j = $urandom_range(0, 1); j > 0; j--) begin
                instr_valid = 1'b0; mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk); chk_all("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, z); tick();
            end
        end

        // reset while waiting in MEM
        instr = 32'h0080A283; instr_valid = 1'b1; mem_ack = 1'b0; muldiv_done = 1'b0;
        tick();
        instr_valid = 1'b0;
        tick(); tick();
        @(negedge clk); chk("rstmem.mem_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        exp_ret = 0;
        @(negedge clk); chk_all("rstmem", 1, 0, 0, 0, 0, 0, 0, 0, 0, z); tick();
        run_instr(32'h002081B3, 0);

        // M-extension disabled: mul decodes as illegal
        b_instr = 32'h022081B3; b_valid = 1'b1;
        @(negedge clk); chk("nomd.ir_we", 32'(b_irwe), 32'd1); tick();
        b_valid = 1'b0;
        @(negedge clk);
        chk("nomd.illegal", 32'(b_ill), 32'(!model(32'h022081B3, 1'b0).legal));
        chk("nomd.pc_we", 32'(b_pcwe), 32'd0);
        tick();
        @(negedge clk);
        chk("nomd.ready", 32'(b_ready), 32'd1);
        chk("nomd.illegal_gone", 32'(b_ill), 32'd0);
        chk("nomd.retired", b_retired, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            assert (32'($countones({illegal, md_timeout, pc_we})) <= 32'd1) else begin
                fails++;
                $error("FAIL excl observed=%0b expected=at most one", {illegal, md_timeout, pc_we});
            end
        end
    end

endmodule
